// File: rtl/mult_datapath_pkg.sv
// Shared constants for the sequential 8x8 multiplier: shift codes, step counts and widths.
// The control FSM imports the same package so both sides agree on the step encoding.
package mult_datapath_pkg;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned PP_W   = 8;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned CNT_W  = 3;

    // Partial-product shift codes; 2'b11 is reserved and behaves as no shift.
    typedef enum logic [1:0] {
        SHIFT_0    = 2'b00,
        SHIFT_4    = 2'b01,
        SHIFT_8    = 2'b10,
        SHIFT_RSVD = 2'b11
    } shift_e;

    localparam logic [CNT_W-1:0] COUNT_IDLE   = 3'd0;
    localparam logic [CNT_W-1:0] COUNT_S0     = 3'd1;
    localparam logic [CNT_W-1:0] COUNT_S1     = 3'd2;
    localparam logic [CNT_W-1:0] COUNT_S2     = 3'd3;
    localparam logic [CNT_W-1:0] COUNT_S3     = 3'd4;
    localparam logic [CNT_W-1:0] COUNT_FINISH = 3'd5;

    // Pick the high (sel = 1) or low nibble of an operand byte.
    function automatic logic [NIB_W-1:0] nibble(input logic [WIDTH-1:0] v, input logic sel);
        return sel ? v[WIDTH-1:NIB_W] : v[NIB_W-1:0];
    endfunction

endpackage

// File: rtl/mult4x4.sv
// Combinational 4x4 -> 8 unsigned multiplier used for each partial product.
module mult4x4
    import mult_datapath_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    output logic [PP_W-1:0]  p
);

    // Zero-extend before multiplying so the full 8-bit product is kept.
    always_comb begin
        p = PP_W'(a) * PP_W'(b);
    end

endmodule

// File: rtl/mult_datapath.sv
// Datapath of the sequential 8x8 multiplier: operand latches, step counter, one shifted
// 4x4 partial product per step, a 16-bit accumulator and the committed result register.
module mult_datapath
    import mult_datapath_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  dataa,
    input  logic [WIDTH-1:0]  datab,
    input  logic              sela,
    input  logic              selb,
    input  logic [1:0]        sel_shifter,
    input  logic              data_sel,
    input  logic              clk_en,
    input  logic              done_flag,
    output logic [CNT_W-1:0]  count,
    output logic [PROD_W-1:0] product,
    output logic              product_valid
);

    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [PROD_W-1:0] acc;
    logic [NIB_W-1:0]  a_nib;
    logic [NIB_W-1:0]  b_nib;
    logic [PP_W-1:0]   pp;
    logic [PROD_W-1:0] term;
    logic              load;

    // A new operation is accepted only while the counter is idle and no step is running.
    assign load  = start && !clk_en && (count == COUNT_IDLE);
    assign a_nib = nibble(a_reg, sela);
    assign b_nib = nibble(b_reg, selb);

    mult4x4 u_mult4x4 (
        .a (a_nib),
        .b (b_nib),
        .p (pp)
    );

    // Position the partial product; the reserved code falls through to no shift.
    always_comb begin
        term = '0;
        unique case (shift_e'(sel_shifter))
            SHIFT_8: term = {pp, 8'h00};
            SHIFT_4: term = {4'h0, pp, 4'h0};
            default: term = {8'h00, pp};
        endcase
    end

    // Operand latches, written only on the load event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (load) begin
            a_reg <= dataa;
            b_reg <= datab;
        end
    end

    // Accumulator: strobes are only consumed on enabled steps so idle-time X cannot leak in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clk_en) begin
            acc <= data_sel ? term : acc + term;
        end
    end

    // Step counter: done_flag clears it ahead of any increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= COUNT_IDLE;
        end else if (done_flag) begin
            count <= COUNT_IDLE;
        end else if (clk_en) begin
            count <= count + 3'd1;
        end else if (load) begin
            count <= COUNT_S0;
        end
    end

    // Result register: commit the pre-edge accumulator on done, invalidate on a new load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            product       <= '0;
            product_valid <= 1'b0;
        end else if (done_flag) begin
            product       <= acc;
            product_valid <= 1'b1;
        end else if (load) begin
            product_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath; a small FSM emulation drives the strobes and
// results are compared against plain a*b arithmetic.
module tb_mult_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  dataa = '0;
    logic [7:0]  datab = '0;
    logic        sela = 1'b0;
    logic        selb = 1'b0;
    logic [1:0]  sel_shifter = 2'b00;
    logic        data_sel = 1'b0;
    logic        clk_en = 1'b0;
    logic        done_flag = 1'b0;
    logic [2:0]  count;
    logic [15:0] product;
    logic        product_valid;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        bit          hold;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[7];

    mult_datapath dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .dataa         (dataa),
        .datab         (datab),
        .sela          (sela),
        .selb          (selb),
        .sel_shifter   (sel_shifter),
        .data_sel      (data_sel),
        .clk_en        (clk_en),
        .done_flag     (done_flag),
        .count         (count),
        .product       (product),
        .product_valid (product_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobes for enabled step s (0..3): hi*hi<<8, hi*lo<<4, lo*hi<<4, lo*lo.
    task automatic set_step(input int s);
        clk_en      = 1'b1;
        sela        = (s < 2);
        selb        = (s == 0) || (s == 2);
        sel_shifter = (s == 0) ? 2'b10 : (s == 3) ? 2'b00 : 2'b01;
        data_sel    = (s == 0);
    endtask

    task automatic load_op(input logic [7:0] a, input logic [7:0] b);
        start = 1'b1; dataa = a; datab = b; clk_en = 1'b0; done_flag = 1'b0;
        tick();
        check("load_count", 16'(count), 16'd1);
        check("load_valid_drop", 16'(product_valid), 16'd0);
    endtask

    // Full operation as the control FSM would sequence it.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit hold,
                          input logic [15:0] exp);
        load_op(a, b);
        if (!hold) start = 1'b0;
        dataa = 8'($urandom);
        datab = 8'($urandom);
        for (int s = 0; s < 4; s++) begin
            set_step(s);
            tick();
            check("step_count", 16'(count), 16'(s + 2));
            check("step_valid", 16'(product_valid), 16'd0);
        end
        clk_en = 1'b0; done_flag = 1'b1;
        sela = 1'($urandom); selb = 1'($urandom); sel_shifter = 2'($urandom);
        data_sel = 1'($urandom);
        tick();
        done_flag = 1'b0; start = 1'b0;
        check("op_product", product, exp);
        check("op_valid", 16'(product_valid), 16'd1);
        check("op_count", 16'(count), 16'd0);
    endtask

    initial begin
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [15:0] partial;

        vecs[0] = '{a: 8'hFF, b: 8'hFF, hold: 1'b0, exp: 16'hFE01};
        vecs[1] = '{a: 8'h12, b: 8'h34, hold: 1'b0, exp: 16'h03A8};
        vecs[2] = '{a: 8'h12, b: 8'h34, hold: 1'b1, exp: 16'h03A8};
        vecs[3] = '{a: 8'h00, b: 8'h7B, hold: 1'b0, exp: 16'h0000};
        vecs[4] = '{a: 8'h80, b: 8'h02, hold: 1'b0, exp: 16'h0100};
        vecs[5] = '{a: 8'hFF, b: 8'h01, hold: 1'b1, exp: 16'h00FF};
        vecs[6] = '{a: 8'h0F, b: 8'h10, hold: 1'b0, exp: 16'h00F0};

        // Reset state
        #3;
        check("rst_count", 16'(count), 16'd0);
        check("rst_product", product, 16'h0000);
        check("rst_valid", 16'(product_valid), 16'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].exp);

        // Random operands against plain multiplication
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(ra, rb, 1'($urandom), 16'(ra) * 16'(rb));
        end

        // Busy start is ignored: after a load, start with clk_en low mid-operation
        load_op(8'h21, 8'h43);
        set_step(0); tick();
        clk_en = 1'b0; start = 1'b1; dataa = 8'h99; datab = 8'h99;
        tick();
        check("busy_start_count", 16'(count), 16'd2);
        start = 1'b0;
        for (int s = 1; s < 4; s++) begin set_step(s); tick(); end
        clk_en = 1'b0; done_flag = 1'b1; tick(); done_flag = 1'b0;
        check("busy_start_product", product, 16'(8'h21) * 16'(8'h43));

        // Asynchronous reset during S2
        load_op(8'hFF, 8'hFF);
        start = 1'b0;
        set_step(0); tick();
        set_step(1); tick();
        check("pre_rst_count", 16'(count), 16'd3);
        #2 rst = 1'b0;
        #1;
        check("async_rst_count", 16'(count), 16'd0);
        check("async_rst_product", product, 16'h0000);
        check("async_rst_valid", 16'(product_valid), 16'd0);
        clk_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        run_op(8'h0F, 8'h10, 1'b0, 16'h00F0);

        // Standalone: reserved shift acts as <<0, and clk_en low holds the accumulator
        load_op(8'h30, 8'h50);
        start = 1'b0;
        clk_en = 1'b1; data_sel = 1'b1; sel_shifter = 2'b11; sela = 1'b1; selb = 1'b1;
        tick();
        clk_en = 1'b0; done_flag = 1'b1; tick(); done_flag = 1'b0;
        check("rsvd_shift_acc", product, 16'h000F);
        data_sel = 1'b0; clk_en = 1'b0;
        tick();
        done_flag = 1'b1; tick(); done_flag = 1'b0;
        check("clk_en_low_hold", product, 16'h000F);

        // Forced clk_en and done_flag together at count 4
        ra = 8'h12; rb = 8'h34;
        partial = 16'(ra) * 16'(rb) - 16'(ra[3:0]) * 16'(rb[3:0]);
        load_op(ra, rb);
        start = 1'b0;
        for (int s = 0; s < 3; s++) begin set_step(s); tick(); end
        check("forced_pre_count", 16'(count), 16'd4);
        set_step(3); done_flag = 1'b1;
        tick();
        check("forced_count", 16'(count), 16'd0);
        check("forced_product", product, partial);
        clk_en = 1'b0;
        tick();
        check("forced_acc_updated", product, 16'(ra) * 16'(rb));
        done_flag = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
